// File: rtl/sound_mailbox_ctrl.sv
// Clocked 68K <-> Z80 sound mailbox.
// Synchronizes the asynchronous bus strobes and detects their edges. Latches the
// command and reply bytes and keeps the pending, reply-valid and overrun flags.
// Generates a fixed-width Z80 NMI pulse for each new command while NMI is enabled.
module sound_mailbox_ctrl #(
  parameter int NMI_CYCLES  = 8,  // NMI low-pulse width in CLK cycles (1..255)
  parameter int SYNC_STAGES = 2   // synchronizer depth for async strobes (>= 2)
) (
  input  logic       CLK,
  input  logic       nSDZ80CLR,
  input  logic       nICOM_ZONE,
  input  logic       RW,
  input  logic [7:0] M68K_DIN,
  output logic [7:0] M68K_DOUT,
  input  logic       nSDZ80R,
  input  logic       nSDZ80W,
  input  logic [7:0] SDD_IN,
  output logic [7:0] SDD_OUT,
  input  logic       NMI_EN_SET,
  input  logic       NMI_EN_CLR,
  output logic       nZ80NMI,
  output logic       CMD_PENDING,
  output logic       REP_VALID,
  output logic       OVERRUN
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PULSE    = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  localparam logic [7:0] CNT_LOAD = 8'(NMI_CYCLES - 1);

  // Strobe lanes. All lanes idle high, so they share one reset value.
  localparam int NSTB   = 6;
  localparam int L_WR   = 0;  // nICOM_ZONE | RW   : low while 68K writes
  localparam int L_RD   = 1;  // nICOM_ZONE | ~RW  : low while 68K reads
  localparam int L_ZR   = 2;  // nSDZ80R
  localparam int L_ZW   = 3;  // nSDZ80W
  localparam int L_ESET = 4;  // NMI_EN_SET
  localparam int L_ECLR = 5;  // NMI_EN_CLR

  logic [NSTB-1:0]                  strobe_raw;
  logic [SYNC_STAGES-1:0][NSTB-1:0] sync_q;
  logic [NSTB-1:0]                  prev_q;
  logic [NSTB-1:0]                  strobe_s;
  logic [NSTB-1:0]                  fell;
  logic [NSTB-1:0]                  rose;

  logic       wr68, rd68_end, z80rd, z80wr, en_set, en_clr;
  logic       nmi_rise, arm_wr, run;
  logic [1:0] rst_sync_q;

  logic [7:0] cmd_q, rep_q;
  logic       cmd_pending_q, rep_valid_q, overrun_q, nmi_en_q;

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  assign strobe_raw = {NMI_EN_CLR, NMI_EN_SET, nSDZ80W, nSDZ80R,
                       nICOM_ZONE | ~RW, nICOM_ZONE | RW};

  // Synchronizer chain plus one history flop per lane for edge detection.
  always_ff @(posedge CLK or negedge nSDZ80CLR) begin
    if (!nSDZ80CLR) begin
      // NOTE: the flops reset to the idle (high) level. This way, leaving reset
      // with idle strobes does not produce a false edge.
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples pre-edge values, whatever order the statements appear in.
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe_s = sync_q[SYNC_STAGES-1];
  assign fell     = prev_q & ~strobe_s;
  assign rose     = ~prev_q & strobe_s;

  assign wr68     = fell[L_WR];
  assign rd68_end = rose[L_RD];
  assign z80rd    = fell[L_ZR];
  assign z80wr    = rose[L_ZW];
  assign en_set   = fell[L_ESET];
  assign en_clr   = fell[L_ECLR];

  // Reset release passes through two flops before the FSM may leave IDLE.
  always_ff @(posedge CLK or negedge nSDZ80CLR) begin
    if (!nSDZ80CLR) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run = rst_sync_q[1];

  // Command/reply latches and the status flags. A new write beats a same-cycle read.
  always_ff @(posedge CLK or negedge nSDZ80CLR) begin
    if (!nSDZ80CLR) begin
      cmd_q         <= 8'h00;
      rep_q         <= 8'h00;
      cmd_pending_q <= 1'b0;
      rep_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      nmi_en_q      <= 1'b0;
    end else begin
      if (wr68) begin
        cmd_q         <= M68K_DIN;
        cmd_pending_q <= 1'b1;
        if (cmd_pending_q) overrun_q <= 1'b1;
      end else if (z80rd) begin
        cmd_pending_q <= 1'b0;
      end

      if (z80wr) begin
        rep_q       <= SDD_IN;
        rep_valid_q <= 1'b1;
      end else if (rd68_end) begin
        rep_valid_q <= 1'b0;
      end

      if (en_clr)      nmi_en_q <= 1'b0;
      else if (en_set) nmi_en_q <= 1'b1;
    end
  end

  // nmi_en going 0 -> 1 this cycle (CLR has priority over SET).
  assign nmi_rise = en_set & ~en_clr & ~nmi_en_q;
  assign arm_wr   = wr68 & nmi_en_q;

  // NMI sequencer: next-state logic.
  always_comb begin
    // NOTE: defaults first. This way, every path assigns the outputs and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (run && (arm_wr || (nmi_rise && cmd_pending_q))) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 8'd0) state_d = ST_WAIT_ACK;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_WAIT_ACK: begin
        if (arm_wr) begin
          state_d = ST_PULSE;
          cnt_d   = CNT_LOAD;
        end else if (z80rd) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // NMI sequencer: state and pulse counter registers.
  always_ff @(posedge CLK or negedge nSDZ80CLR) begin
    if (!nSDZ80CLR) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nZ80NMI     = (state_q != ST_PULSE);
  assign SDD_OUT     = cmd_q;
  assign M68K_DOUT   = rep_q;
  assign CMD_PENDING = cmd_pending_q;
  assign REP_VALID   = rep_valid_q;
  assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_sound_mailbox_ctrl.sv
// Self-checking bench for sound_mailbox_ctrl.
// The reference model delays each raw strobe by the synchronizer latency and
// applies the mailbox rules to the resulting edges. It times the NMI pulse as a
// number of cycles left. Directed scenarios come first, then randomized traffic.
module tb_sound_mailbox_ctrl;

  localparam int NMI_CYCLES = 8;
  localparam int SYNC       = 2;

  logic       CLK = 1'b0;
  logic       nSDZ80CLR, nICOM_ZONE, RW, nSDZ80R, nSDZ80W, NMI_EN_SET, NMI_EN_CLR;
  logic [7:0] M68K_DIN, SDD_IN;
  logic [7:0] M68K_DOUT, SDD_OUT;
  logic       nZ80NMI, CMD_PENDING, REP_VALID, OVERRUN;

  always #5 CLK = ~CLK;

  sound_mailbox_ctrl #(.NMI_CYCLES(NMI_CYCLES), .SYNC_STAGES(SYNC)) dut (
    .CLK        (CLK),
    .nSDZ80CLR  (nSDZ80CLR),
    .nICOM_ZONE (nICOM_ZONE),
    .RW         (RW),
    .M68K_DIN   (M68K_DIN),
    .M68K_DOUT  (M68K_DOUT),
    .nSDZ80R    (nSDZ80R),
    .nSDZ80W    (nSDZ80W),
    .SDD_IN     (SDD_IN),
    .SDD_OUT    (SDD_OUT),
    .NMI_EN_SET (NMI_EN_SET),
    .NMI_EN_CLR (NMI_EN_CLR),
    .nZ80NMI    (nZ80NMI),
    .CMD_PENDING(CMD_PENDING),
    .REP_VALID  (REP_VALID),
    .OVERRUN    (OVERRUN)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  bit [5:0] h [SYNC+2];   // raw strobe history, h[0] = newest sample
  bit [7:0] e_cmd, e_rep;
  bit       e_pend, e_valid, e_ovr, e_en, e_wait;
  int       e_pulse_left;
  int       e_rel;

  // Observation counters for the directed scenarios.
  int low_seen = 0;
  int pulses   = 0;
  bit prev_nmi = 1'b1;

  function automatic void model_reset();
    for (int i = 0; i < SYNC + 2; i++) h[i] = 6'h3F;
    e_cmd = 8'h00; e_rep = 8'h00;
    e_pend = 1'b0; e_valid = 1'b0; e_ovr = 1'b0; e_en = 1'b0; e_wait = 1'b0;
    e_pulse_left = 0;
    e_rel = 0;
  endfunction

  task automatic model_step();
    bit [5:0] fell, rose;
    bit wr68, rd68_end, z80rd, z80wr, en_set, en_clr, old_en, old_pend, en_rise;
    if (!nSDZ80CLR) begin
      model_reset();
      return;
    end
    for (int i = SYNC + 1; i > 0; i--) h[i] = h[i-1];
    h[0] = {NMI_EN_CLR, NMI_EN_SET, nSDZ80W, nSDZ80R, nICOM_ZONE | ~RW, nICOM_ZONE | RW};
    fell = h[SYNC+1] & ~h[SYNC];
    rose = ~h[SYNC+1] & h[SYNC];
    wr68 = fell[0]; rd68_end = rose[1]; z80rd = fell[2];
    z80wr = rose[3]; en_set = fell[4]; en_clr = fell[5];
    e_rel++;
    old_en   = e_en;
    old_pend = e_pend;
    en_rise  = en_set && !en_clr && !old_en;

    if (e_pulse_left > 0) begin
      e_pulse_left--;
      if (e_pulse_left == 0) e_wait = 1'b1;
    end else if (e_wait) begin
      if (wr68 && old_en) begin
        e_pulse_left = NMI_CYCLES;
        e_wait = 1'b0;
      end else if (z80rd) begin
        e_wait = 1'b0;
      end
    end else if (e_rel >= 3 && ((wr68 && old_en) || (en_rise && old_pend))) begin
      e_pulse_left = NMI_CYCLES;
    end

    if (en_clr)      e_en = 1'b0;
    else if (en_set) e_en = 1'b1;
    if (wr68) begin
      if (old_pend) e_ovr = 1'b1;
      e_pend = 1'b1;
      e_cmd  = M68K_DIN;
    end else if (z80rd) begin
      e_pend = 1'b0;
    end
    if (z80wr) begin
      e_rep   = SDD_IN;
      e_valid = 1'b1;
    end else if (rd68_end) begin
      e_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("sdd_out",     32'(SDD_OUT),     32'(e_cmd));
    check("m68k_dout",   32'(M68K_DOUT),   32'(e_rep));
    check("nz80nmi",     32'(nZ80NMI),     (e_pulse_left > 0) ? 32'd0 : 32'd1);
    check("cmd_pending", 32'(CMD_PENDING), 32'(e_pend));
    check("rep_valid",   32'(REP_VALID),   32'(e_valid));
    check("overrun",     32'(OVERRUN),     32'(e_ovr));
  endtask

  // One clock: the model steps on the edge, and the outputs are compared mid-cycle.
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
    if (!nZ80NMI) low_seen++;
    if (prev_nmi && !nZ80NMI) pulses++;
    prev_nmi = nZ80NMI;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic m68_write(input logic [7:0] d);
    M68K_DIN = d; RW = 1'b0; nICOM_ZONE = 1'b0;
    ticks(2);
    nICOM_ZONE = 1'b1; RW = 1'b1;
    ticks(4);
  endtask

  task automatic m68_read();
    RW = 1'b1; nICOM_ZONE = 1'b0;
    ticks(2);
    nICOM_ZONE = 1'b1;
    ticks(4);
  endtask

  task automatic z80_read();
    nSDZ80R = 1'b0; ticks(2);
    nSDZ80R = 1'b1; ticks(4);
  endtask

  task automatic z80_write(input logic [7:0] d);
    SDD_IN = d; nSDZ80W = 1'b0; ticks(2);
    nSDZ80W = 1'b1; ticks(4);
  endtask

  task automatic nmi_enable();
    NMI_EN_SET = 1'b0; ticks(2);
    NMI_EN_SET = 1'b1; ticks(4);
  endtask

  task automatic nmi_disable();
    NMI_EN_CLR = 1'b0; ticks(2);
    NMI_EN_CLR = 1'b1; ticks(4);
  endtask

  initial begin
    int lat, w;
    nSDZ80CLR = 1'b0; nICOM_ZONE = 1'b1; RW = 1'b1; nSDZ80R = 1'b1; nSDZ80W = 1'b1;
    NMI_EN_SET = 1'b1; NMI_EN_CLR = 1'b1; M68K_DIN = 8'h00; SDD_IN = 8'h00;
    model_reset();

    // Reset state.
    @(negedge CLK);
    compare_all();
    check("rst_nmi", 32'(nZ80NMI), 32'd1);
    check("rst_sdd", 32'(SDD_OUT), 32'h00);
    ticks(2);
    nSDZ80CLR = 1'b1;
    ticks(4);

    // Scenario 1: enabled NMI. Check latency and width of the pulse, then the Z80 read.
    nmi_enable();
    M68K_DIN = 8'h5A; RW = 1'b0; nICOM_ZONE = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (nZ80NMI && lat < 12);
    check("s1_nmi_latency", 32'(lat), 32'd3);
    nICOM_ZONE = 1'b1; RW = 1'b1;
    w = 1;
    while (!nZ80NMI && w < 40) begin
      tick();
      if (!nZ80NMI) w++;
    end
    check("s1_nmi_width", 32'(w), 32'd8);
    check("s1_sdd_out", 32'(SDD_OUT), 32'h5A);
    check("s1_pending", 32'(CMD_PENDING), 32'd1);
    z80_read();
    check("s1_pending_clr", 32'(CMD_PENDING), 32'd0);

    // Scenario 2: no NMI while disabled. A later enable fires for the pending command.
    nmi_disable();
    low_seen = 0; pulses = 0;
    m68_write(8'h11);
    ticks(10);
    check("s2_no_nmi", 32'(low_seen), 32'd0);
    check("s2_pending", 32'(CMD_PENDING), 32'd1);
    nmi_enable();
    ticks(14);
    check("s2_late_low", 32'(low_seen), 32'd8);
    check("s2_late_pulses", 32'(pulses), 32'd1);
    z80_read();

    // Scenario 3: back-to-back commands. Check the overrun and the re-armed pulse.
    low_seen = 0; pulses = 0;
    m68_write(8'h01);
    ticks(12);
    m68_write(8'h02);
    ticks(12);
    check("s3_sdd_out", 32'(SDD_OUT), 32'h02);
    check("s3_overrun", 32'(OVERRUN), 32'd1);
    check("s3_low", 32'(low_seen), 32'd16);
    check("s3_pulses", 32'(pulses), 32'd2);
    z80_read();
    ticks(5);
    check("s3_overrun_sticky", 32'(OVERRUN), 32'd1);

    // Scenario 4: reply path, including a Z80 write that coincides with the 68K read end.
    z80_write(8'hC3);
    check("s4_dout", 32'(M68K_DOUT), 32'hC3);
    check("s4_valid", 32'(REP_VALID), 32'd1);
    m68_read();
    check("s4_valid_clr", 32'(REP_VALID), 32'd0);
    SDD_IN = 8'h3C; nSDZ80W = 1'b0; RW = 1'b1; nICOM_ZONE = 1'b0;
    ticks(2);
    nSDZ80W = 1'b1; nICOM_ZONE = 1'b1;
    ticks(4);
    check("s4_coinc_valid", 32'(REP_VALID), 32'd1);
    check("s4_coinc_dout", 32'(M68K_DOUT), 32'h3C);

    // Scenario 5: asynchronous reset in the fourth cycle of a pulse.
    M68K_DIN = 8'h9E; RW = 1'b0; nICOM_ZONE = 1'b0;
    ticks(2);
    nICOM_ZONE = 1'b1; RW = 1'b1;
    w = 0;
    while (nZ80NMI && w < 12) begin
      tick();
      w++;
    end
    check("s5_pulse_started", 32'(nZ80NMI), 32'd0);
    ticks(3);
    nSDZ80CLR = 1'b0;
    #1;
    model_reset();
    check("s5_rst_nmi", 32'(nZ80NMI), 32'd1);
    check("s5_rst_sdd", 32'(SDD_OUT), 32'h00);
    check("s5_rst_dout", 32'(M68K_DOUT), 32'h00);
    check("s5_rst_flags", 32'({CMD_PENDING, REP_VALID, OVERRUN}), 32'd0);
    ticks(2);
    nSDZ80CLR = 1'b1;
    low_seen = 0;
    ticks(20);
    check("s5_no_pulse", 32'(low_seen), 32'd0);

    // Scenario 6: a new command and the Z80 read land together in WAIT_ACK.
    nmi_enable();
    m68_write(8'h33);
    ticks(12);
    low_seen = 0; pulses = 0;
    M68K_DIN = 8'h77; RW = 1'b0; nICOM_ZONE = 1'b0; nSDZ80R = 1'b0;
    ticks(2);
    nICOM_ZONE = 1'b1; RW = 1'b1; nSDZ80R = 1'b1;
    ticks(16);
    check("s6_pending", 32'(CMD_PENDING), 32'd1);
    check("s6_sdd_out", 32'(SDD_OUT), 32'h77);
    check("s6_low", 32'(low_seen), 32'd8);
    check("s6_pulses", 32'(pulses), 32'd1);

    // Randomized traffic, compared against the model on every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) nICOM_ZONE = ~nICOM_ZONE;
      if ($urandom_range(0, 3) == 0) RW = ~RW;
      if ($urandom_range(0, 3) == 0) nSDZ80R = ~nSDZ80R;
      if ($urandom_range(0, 3) == 0) nSDZ80W = ~nSDZ80W;
      if ($urandom_range(0, 7) == 0) NMI_EN_SET = ~NMI_EN_SET;
      if ($urandom_range(0, 15) == 0) NMI_EN_CLR = ~NMI_EN_CLR;
      M68K_DIN = 8'($urandom);
      SDD_IN   = 8'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        nSDZ80CLR = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        nSDZ80CLR = 1'b1;
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sound_mailbox_ctrl.md
Name: sound_mailbox_ctrl

Overview:
Synchronous controller for the 68K<->Z80 sound command/reply mailbox. It samples the asynchronous 68K REG_SOUND strobes and Z80 port strobes in the system clock domain and latches the command and reply bytes. It sequences Z80 NMI pulses on each new command and tracks the pending, reply-valid and overrun status. It sits between the 68K I/O decode and the Z80 port decode, replacing the free-running latches with a clocked, verifiable handshake.

Parameters:
NMI_CYCLES, 8, NMI low-pulse width in CLK cycles (range 1..255)
SYNC_STAGES, 2, synchronizer depth for async strobes (minimum 2)

Ports:
CLK  in  1  system clock
nSDZ80CLR  in  1  reset, asynchronous, active-low
nICOM_ZONE  in  1  68K REG_SOUND select, active-low, async
RW  in  1  68K read/write (1 = read), async
M68K_DIN  in  8  68K data bits 15:8
M68K_DOUT  out  8  reply byte to 68K
nSDZ80R  in  1  Z80 command-port read strobe, active-low, async
nSDZ80W  in  1  Z80 reply-port write strobe, active-low, async
SDD_IN  in  8  Z80 data bus in
SDD_OUT  out  8  command byte to Z80
NMI_EN_SET  in  1  Z80 NMI-enable port strobe, active-low, async
NMI_EN_CLR  in  1  Z80 NMI-disable port strobe, active-low, async
nZ80NMI  out  1  Z80 NMI, active-low
CMD_PENDING  out  1  command written, not yet read by Z80
REP_VALID  out  1  reply written, not yet read by 68K
OVERRUN  out  1  sticky: command overwritten while pending

Behaviour:
- Reset (nSDZ80CLR low, async): cmd latch=0x00, reply latch=0x00, SDD_OUT=0x00, M68K_DOUT=0x00, nZ80NMI=1, CMD_PENDING=0, REP_VALID=0, OVERRUN=0, nmi_en=0, FSM=IDLE, counter=0. Deassertion is synchronized (2 FF) before the FSM leaves IDLE.
- All strobes pass through SYNC_STAGES flops; edges are detected on the synchronized copies. M68K_DIN and SDD_IN are sampled in the same cycle the edge is detected.
- wr68 = falling edge of (nICOM_ZONE | RW); rd68_end = rising edge of (nICOM_ZONE | ~RW); z80rd = falling edge of nSDZ80R; z80wr = rising edge of nSDZ80W.
- wr68: cmd latch <= M68K_DIN; CMD_PENDING <= 1; if CMD_PENDING was already 1, OVERRUN <= 1.
- z80rd: CMD_PENDING <= 0. If wr68 occurs in the same cycle, wr68 wins and CMD_PENDING stays 1.
- z80wr: reply latch <= SDD_IN; REP_VALID <= 1.
- rd68_end: REP_VALID <= 0. If z80wr occurs in the same cycle, z80wr wins.
- SDD_OUT and M68K_DOUT continuously reflect the latches. Tristating is external.
- NMI_EN_SET edge sets nmi_en=1; NMI_EN_CLR edge sets nmi_en=0. If both occur in the same cycle, CLR wins.
- FSM states:
  - IDLE: nZ80NMI=1. Go to PULSE when (wr68 & nmi_en), or when nmi_en rises while CMD_PENDING=1. Load counter=NMI_CYCLES-1.
  - PULSE: nZ80NMI=0. Counter decrements each cycle; at 0, go to WAIT_ACK. A wr68 in PULSE updates the latch but does not extend the pulse. nmi_en cleared in PULSE: the pulse completes anyway.
  - WAIT_ACK: nZ80NMI=1. z80rd goes to IDLE. wr68 with nmi_en goes back to PULSE (re-arm). wr68 and z80rd in the same cycle go to PULSE.
- Latency: the first nZ80NMI low is SYNC_STAGES+1 CLK after the 68K strobe falls. The pulse lasts exactly NMI_CYCLES cycles.
- Reset mid-PULSE: nZ80NMI returns to 1 immediately (async).

Test Plan:
- Reset, nmi_en=1, 68K writes 0x5A -> SDD_OUT=0x5A, CMD_PENDING=1, nZ80NMI low for exactly 8 CLK starting 3 CLK after strobe; Z80 read -> CMD_PENDING=0, FSM IDLE.
- nmi_en=0, write 0x11 -> no NMI, CMD_PENDING=1; then NMI_EN_SET -> one 8-cycle pulse.
- Write 0x01 then 0x02 with no Z80 read -> SDD_OUT=0x02, OVERRUN=1, two NMI pulses (second from WAIT_ACK); OVERRUN holds until reset.
- Z80 writes 0xC3 -> M68K_DOUT=0xC3, REP_VALID=1; 68K read completes -> REP_VALID=0; z80wr coincident with rd68_end -> REP_VALID stays 1.
- Assert nSDZ80CLR during PULSE cycle 4 -> nZ80NMI=1, SDD_OUT=0x00, all flags 0 in the same cycle; after release, no pulse until a new write.
- Coincident wr68 (0x77) and z80rd in WAIT_ACK -> CMD_PENDING=1, new 8-cycle pulse, SDD_OUT=0x77.
